// File: rtl/xu_cr0_rec_buf.sv
// Record-form CR0 builder with a 2-entry ordered buffer toward CR writeback.
// Also keeps a saturating count of delivered EQ results.
module xu_cr0_rec_buf #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic                 in_val,
   output logic                 in_ready,
   input  logic                 in_or_hi,
   input  logic                 in_or_lo,
   input  logic                 in_msb0,
   input  logic                 in_msb32,
   input  logic                 in_is64,
   input  logic                 in_so,
   input  logic                 flush,
   output logic                 out_val,
   input  logic                 out_ready,
   output logic [3:0]           out_cr,
   input  logic                 cnt_clr,
   output logic [CNT_WIDTH-1:0] eq_cnt
);

   logic [3:0] mem [2];
   logic       head_ptr;
   logic       tail_ptr;
   logic [1:0] count;
   logic [1:0] next_count;
   logic       zero;
   logic       neg;
   logic [3:0] new_cr;
   logic       push;
   logic       pop;

   // cr bit order: [3]=LT [2]=GT [1]=EQ [0]=SO
   always_comb begin
      zero   = in_is64 ? ~(in_or_hi | in_or_lo) : ~in_or_lo;
      neg    = in_is64 ? in_msb0 : in_msb32;
      new_cr = {neg & ~zero, ~neg & ~zero, zero, in_so};
   end

   assign push   = in_val & in_ready & ~flush;
   assign pop    = out_val & out_ready;
   assign out_cr = mem[head_ptr];

   always_comb begin
      next_count = count;
      if (flush)
         next_count = 2'd0;
      else if (push && !pop)
         next_count = count + 2'd1;
      else if (pop && !push)
         next_count = count - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         mem[0]   <= 4'b0000;
         mem[1]   <= 4'b0000;
         head_ptr <= 1'b0;
         tail_ptr <= 1'b0;
         count    <= 2'd0;
         out_val  <= 1'b0;
         in_ready <= 1'b1;
         eq_cnt   <= '0;
      end else begin
         if (flush) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
         end else begin
            if (push) begin
               mem[tail_ptr] <= new_cr;
               tail_ptr      <= ~tail_ptr;
            end
            if (pop)
               head_ptr <= ~head_ptr;
         end
         count    <= next_count;
         out_val  <= (next_count != 2'd0);
         in_ready <= (next_count != 2'd2);
         // a pop completing alongside flush was seen by writeback, so it still counts
         if (cnt_clr)
            eq_cnt <= '0;
         else if (pop && mem[head_ptr][1] && (eq_cnt != {CNT_WIDTH{1'b1}}))
            eq_cnt <= eq_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_xu_cr0_rec_buf.sv
// Directed bench for xu_cr0_rec_buf; a CNT_WIDTH=4 copy shares stimulus for saturation.
module tb_xu_cr0_rec_buf;

   logic        clk = 1'b0;
   logic        rst_b, in_val, in_or_hi, in_or_lo, in_msb0, in_msb32, in_is64, in_so;
   logic        flush, out_ready, cnt_clr;
   logic        in_ready, out_val;
   logic [3:0]  out_cr;
   logic [15:0] eq_cnt;
   logic        in_ready4, out_val4;
   logic [3:0]  out_cr4;
   logic [3:0]  eq_cnt4;

   int errors = 0;
   int checks = 0;
   int exp_eq = 0;

   always #5 clk = ~clk;

   xu_cr0_rec_buf #(.CNT_WIDTH(16)) dut (
      .clk(clk), .rst_b(rst_b), .in_val(in_val), .in_ready(in_ready),
      .in_or_hi(in_or_hi), .in_or_lo(in_or_lo), .in_msb0(in_msb0), .in_msb32(in_msb32),
      .in_is64(in_is64), .in_so(in_so), .flush(flush), .out_val(out_val),
      .out_ready(out_ready), .out_cr(out_cr), .cnt_clr(cnt_clr), .eq_cnt(eq_cnt)
   );

   xu_cr0_rec_buf #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_b(rst_b), .in_val(in_val), .in_ready(in_ready4),
      .in_or_hi(in_or_hi), .in_or_lo(in_or_lo), .in_msb0(in_msb0), .in_msb32(in_msb32),
      .in_is64(in_is64), .in_so(in_so), .flush(flush), .out_val(out_val4),
      .out_ready(out_ready), .out_cr(out_cr4), .cnt_clr(cnt_clr), .eq_cnt(eq_cnt4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic hi, input logic lo, input logic m0, input logic m32,
                        input logic is64, input logic so);
      in_or_hi = hi; in_or_lo = lo; in_msb0 = m0; in_msb32 = m32; in_is64 = is64; in_so = so;
   endtask

   // kind 0 = LT, 1 = GT, 2 = EQ
   task automatic drive_kind(input int kind, input logic so);
      case (kind)
         0:       drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, so);
         1:       drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, so);
         default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, so);
      endcase
   endtask

   function automatic logic [3:0] cr_of(input int kind, input logic so);
      case (kind)
         0:       return {3'b100, so};
         1:       return {3'b010, so};
         default: return {3'b001, so};
      endcase
   endfunction

   task automatic test_reset();
      rst_b = 1'b0; in_val = 1'b0; flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step(); step();
      rst_b = 1'b1;
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b want 0", out_val); end
      checks++; if (out_cr !== 4'b0000) begin errors++; $display("FAIL reset_out_cr: got %b want 0000", out_cr); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (eq_cnt !== 16'd0) begin errors++; $display("FAIL reset_eq_cnt: got %0d want 0", eq_cnt); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      in_val = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      in_val = 1'b0;
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL basic_out_val: got %b want 1", out_val); end
      checks++; if (out_cr !== 4'b0011) begin errors++; $display("FAIL basic_out_cr: got %b want 0011", out_cr); end
      step();
      exp_eq++;
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", out_val); end
      checks++; if (eq_cnt !== 16'd1) begin errors++; $display("FAIL basic_eq_cnt: got %0d want 1", eq_cnt); end
   endtask

   task automatic test_mode();
      logic [5:0] vec [5];
      logic [3:0] exp [5];
      // {hi, lo, msb0, msb32, is64, so}
      vec[0] = 6'b100000; exp[0] = 4'b0010;
      vec[1] = 6'b010100; exp[1] = 4'b1000;
      vec[2] = 6'b100010; exp[2] = 4'b0100;
      vec[3] = 6'b011011; exp[3] = 4'b1001;
      vec[4] = 6'b111000; exp[4] = 4'b0100;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_val = 1'b1;
         drive(vec[i][5], vec[i][4], vec[i][3], vec[i][2], vec[i][1], vec[i][0]);
         step();
         in_val = 1'b0;
         checks++; if (out_cr !== exp[i]) begin errors++; $display("FAIL mode_cr[%0d]: got %b want %b", i, out_cr, exp[i]); end
         step();
      end
      exp_eq++;
      checks++; if (eq_cnt !== 16'(exp_eq)) begin errors++; $display("FAIL mode_eq_cnt: got %0d want %0d", eq_cnt, exp_eq); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_val = 1'b1; drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   // A: 1000
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_1: got %b want 1", in_ready); end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);                   // B: 0101
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_2: got %b want 0", in_ready); end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);                   // C: 0010, held
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
      checks++; if (out_val !== 1'b1 || out_cr !== 4'b1000) begin errors++; $display("FAIL bp_head_A: got val=%b cr=%b want val=1 cr=1000", out_val, out_cr); end
      out_ready = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
      checks++; if (out_cr !== 4'b0101) begin errors++; $display("FAIL bp_head_B: got %b want 0101", out_cr); end
      step();
      in_val = 1'b0;
      checks++; if (out_val !== 1'b1 || out_cr !== 4'b0010) begin errors++; $display("FAIL bp_head_C: got val=%b cr=%b want val=1 cr=0010", out_val, out_cr); end
      step();
      exp_eq++;
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_val); end
      checks++; if (eq_cnt !== 16'(exp_eq)) begin errors++; $display("FAIL bp_eq_cnt: got %0d want %0d", eq_cnt, exp_eq); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_cr;
      int bad = 0;
      out_ready = 1'b0;
      in_val = 1'b1; drive_kind(0, 1'b0);
      step();
      out_ready = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         drive_kind(i % 3, 1'(i & 1));
         step();
         exp_cr = cr_of(i % 3, 1'(i & 1));
         checks++;
         if (out_val !== 1'b1 || out_cr !== exp_cr || in_ready !== 1'b1) begin
            errors++; bad++;
            $display("FAIL b2b_cycle[%0d]: got val=%b cr=%b rdy=%b want val=1 cr=%b rdy=1", i, out_val, out_cr, in_ready, exp_cr);
         end
      end
      in_val = 1'b0;
      step();
      for (int i = 0; i <= 20; i++) if (i % 3 == 2) exp_eq++;
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", out_val); end
      checks++; if (eq_cnt !== 16'(exp_eq)) begin errors++; $display("FAIL b2b_eq_cnt: got %0d want %0d", eq_cnt, exp_eq); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_val = 1'b1; drive_kind(2, 1'b0);
      step(); step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full: got %b want 0", in_ready); end
      flush = 1'b1; out_ready = 1'b1; drive_kind(0, 1'b1);
      step();
      exp_eq++;
      flush = 1'b0;
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL flush_out_val: got %b want 0", out_val); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
      in_val = 1'b0;
      step(); step();
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got %b want 0", out_val); end
      checks++; if (eq_cnt !== 16'(exp_eq)) begin errors++; $display("FAIL flush_eq_cnt: got %0d want %0d", eq_cnt, exp_eq); end
   endtask

   task automatic test_counter();
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      checks++; if (eq_cnt4 !== 4'd0) begin errors++; $display("FAIL cnt_clear: got %0d want 0", eq_cnt4); end
      out_ready = 1'b1;
      in_val = 1'b1; drive_kind(2, 1'b0);
      for (int i = 0; i < 17; i++) step();
      in_val = 1'b0;
      step();
      checks++; if (eq_cnt4 !== 4'd15) begin errors++; $display("FAIL cnt_saturate: got %0d want 15", eq_cnt4); end
      checks++; if (eq_cnt !== 16'd17) begin errors++; $display("FAIL cnt_wide: got %0d want 17", eq_cnt); end
      in_val = 1'b1;
      step();
      in_val = 1'b0; cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      checks++; if (eq_cnt4 !== 4'd0 || eq_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr_wins: got %0d/%0d want 0/0", eq_cnt4, eq_cnt); end
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL cnt_popped: got %b want 0", out_val); end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      in_val = 1'b1; drive_kind(1, 1'b0);
      step();
      rst_b = 1'b0; out_ready = 1'b1;
      step();
      rst_b = 1'b1; in_val = 1'b0;
      checks++; if (out_val !== 1'b0 || in_ready !== 1'b1 || out_cr !== 4'b0000) begin errors++; $display("FAIL mid_reset: got val=%b rdy=%b cr=%b want 0/1/0000", out_val, in_ready, out_cr); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mode();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_counter();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xu_cr0_rec_buf.md
Name: xu_cr0_rec_buf

Overview:
- Downstream consumer of the XU merge OR-reduce (64-bit inverted data -> or_hi/or_lo nonzero flags).
- Takes those two flags plus sign bits and mode, and forms the record-form CR0 field (LT, GT, EQ, SO).
- Buffers results in a 2-entry FIFO with valid/ready handshakes and flush, and keeps a saturating count of EQ results for performance monitoring.
- Sits between the EX merge stage and CR writeback.

Parameters:
CNT_WIDTH, 16, width of the saturating EQ-result counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_b  in  1  synchronous reset, active-low.
in_val  in  1  input record valid.
in_ready  out  1  buffer can accept; registered, equals (count < 2).
in_or_hi  in  1  OR of upper 32 result bits (bits 0:31), from the OR-reduce.
in_or_lo  in  1  OR of lower 32 result bits (bits 32:63), from the OR-reduce.
in_msb0  in  1  result bit 0 (64-bit sign).
in_msb32  in  1  result bit 32 (32-bit sign).
in_is64  in  1  1 = 64-bit compare mode, 0 = 32-bit mode.
in_so  in  1  XER[SO] copied into CR0[3].
flush  in  1  kill all buffered and incoming records.
out_val  out  1  head entry valid.
out_ready  in  1  writeback accepts head.
out_cr  out  4  CR0 [0:3] = LT, GT, EQ, SO of head entry.
cnt_clr  in  1  clear EQ counter.
eq_cnt  out  CNT_WIDTH  saturating count of EQ=1 records delivered.

Behaviour:
- Clocking: one clock, clk. Reset: synchronous, active-low on rst_b.
- Reset values (rst_b=0 at an edge):
  - FIFO count = 0 and both entries invalid.
  - out_val=0, out_cr=4'b0000, in_ready=1, eq_cnt=0.
- CR0 formation (combinational on inputs, stored into the entry at push):
  - zero = in_is64 ? ~(in_or_hi | in_or_lo) : ~in_or_lo.
  - neg = in_is64 ? in_msb0 : in_msb32.
  - LT = neg & ~zero.
  - GT = ~neg & ~zero.
  - EQ = zero.
  - SO = in_so.
  - In 32-bit mode in_or_hi and in_msb0 are ignored. Exactly one of LT/GT/EQ is 1.
- Push: in_val & in_ready at an edge writes the entry at the tail. If in_val is high while in_ready=0, the record is dropped; the producer must hold it.
- Pop: out_val & out_ready at an edge retires the head.
- Latency: a record pushed at edge N (into an empty FIFO) shows out_val=1 and out_cr valid from just after edge N, i.e. one cycle later. No combinational path from in_* to out_*.
- FIFO: 2 entries, ordered, registered head/tail pointers that wrap 1->0.
  - Push and pop in the same cycle with count=1: count stays 1, and the new entry becomes head next cycle.
  - With count=2, in_ready=0 even if out_ready=1. There is no ready pass-through; in_ready updates one cycle after the pop.
  - Pop with count=0 is impossible (out_val=0).
- in_ready is registered: next value = (next_count < 2).
- Flush (flush=1 at an edge):
  - count<=0, pointers<=0, out_val<=0, in_ready<=1.
  - An in_val handshake in the same cycle is discarded.
  - A pop handshake in the same cycle completes (writeback saw it) and is counted.
- Counter:
  - On a pop with the head EQ=1, eq_cnt increments, saturating at all-ones (no wrap).
  - cnt_clr=1 forces eq_cnt<=0; clr wins over a simultaneous increment.
  - Counter is not affected by flush.
- out_cr holds its last value when out_val=0; it is only guaranteed meaningful when out_val=1.
- Reset mid-operation discards all entries regardless of flush or handshakes.

Test Plan:
1. Reset, then push is64=1, or_hi=0, or_lo=0, so=1 with out_ready=1 -> next cycle out_val=1, out_cr=0011; after pop eq_cnt=1.
2. Mode select:
   - is64=0, or_hi=1, or_lo=0 -> out_cr=0010 (EQ).
   - is64=0, or_lo=1, msb32=1, msb0=0 -> 1000 (LT).
   - is64=1, or_hi=1, msb0=0 -> 0100 (GT).
3. Backpressure: out_ready=0, push 3 back-to-back records -> in_ready drops to 0 after the 2nd push and the 3rd is not accepted; raise out_ready -> records retire in order, and in_ready returns to 1 one cycle after the first pop.
4. Simultaneous push and pop at count=1 -> count stays 1, order preserved, and no record is lost or duplicated over 20 alternating cycles.
5. Flush with count=2 plus in_val=1 and a pop in the same cycle -> next cycle out_val=0, in_ready=1; only the popped record is counted, and the incoming record is never output.
6. Counter: CNT_WIDTH=4 override, deliver 17 EQ records -> eq_cnt=15 (saturated); cnt_clr with a concurrent EQ pop -> eq_cnt=0.
